// File: rtl/arb_requester4_pkg.sv
// Constants and helpers shared by the 4-port requester and the round-robin
// arbiter it feeds.
package arb_requester4_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned PORT_IDX_W = 2;

  typedef enum logic {
    PORT_IDLE   = 1'b0,
    PORT_ACTIVE = 1'b1
  } port_state_e;

  // LSB of port p's field inside the packed cmd_len bus.
  function automatic int unsigned len_lsb(input int unsigned port, input int unsigned lenw);
    return port * lenw;
  endfunction

  function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = PORT_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
    return (v & (v - {{(NUM_PORTS-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/arb_requester4_port.sv
// One requester port: single-command holding register with a beat counter
// and the request term presented to the arbiter.
module arb_req_port
  import arb_requester4_pkg::*;
#(
  parameter int unsigned LENW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [LENW-1:0] cmd_len,
  input  logic            grant,
  input  logic            take,
  output logic            cmd_ready,
  output logic            req,
  output logic            pending,
  output logic            consume,
  output logic            final_beat
);

  localparam logic [LENW:0] ONE = (LENW+1)'(1);

  port_state_e   state;
  logic [LENW:0] remaining;
  logic          on_last;

  assign pending    = (state == PORT_ACTIVE);
  assign cmd_ready  = ~pending;
  assign on_last    = (remaining == ONE);
  assign consume    = take & pending;
  assign final_beat = consume & on_last;
  // Drop the request during the final-beat grant so no trailing grant follows.
  assign req        = pending & ~(grant & on_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PORT_IDLE;
      remaining <= '0;
    end else begin
      unique case (state)
        PORT_IDLE: begin
          if (cmd_valid) begin
            remaining <= {1'b0, cmd_len} + ONE;
            state     <= PORT_ACTIVE;
          end
        end
        PORT_ACTIVE: begin
          if (consume) begin
            remaining <= remaining - ONE;
            if (on_last) state <= PORT_IDLE;
          end
        end
        default: state <= PORT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester4.sv
// Four command ports feeding a round-robin arbiter; each grant consumes one
// beat, reported on registered beat/done outputs with a sticky error flag.
module arb_requester4
  import arb_requester4_pkg::*;
#(
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned LENW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      cmd_valid,
  input  logic [NUM_PORTS*LENW-1:0] cmd_len,
  output logic [NUM_PORTS-1:0]      cmd_ready,
  output logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS-1:0]      grant,
  output logic                      beat_valid,
  output logic [PORT_IDX_W-1:0]     beat_port,
  output logic                      beat_last,
  output logic [NUM_PORTS-1:0]      done,
  output logic                      err
);

  if (LENW != $clog2(MAXLEN)) begin : g_bad_lenw
    $error("LENW must equal clog2(MAXLEN)");
  end

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] consume;
  logic [NUM_PORTS-1:0] final_beat;
  logic [NUM_PORTS-1:0] take;
  logic                 grant_multi;
  logic                 grant_bad;

  // A multi-bit grant is wholly rejected; no port consumes a beat from it.
  assign grant_multi = multi_hot(grant);
  assign take        = grant & {NUM_PORTS{~grant_multi}};
  assign grant_bad   = grant_multi | (|(grant & ~pending));

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    arb_req_port #(
      .LENW(LENW)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid[i]),
      .cmd_len   (cmd_len[len_lsb(i, LENW) +: LENW]),
      .grant     (grant[i]),
      .take      (take[i]),
      .cmd_ready (cmd_ready[i]),
      .req       (req[i]),
      .pending   (pending[i]),
      .consume   (consume[i]),
      .final_beat(final_beat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_valid <= 1'b0;
      beat_port  <= '0;
      beat_last  <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
    end else begin
      beat_valid <= |consume;
      beat_port  <= onehot_to_idx(consume);
      beat_last  <= |final_beat;
      done       <= final_beat;
      if (grant_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester4.sv
// Directed bench: stimulus pushes expected beats, a negedge monitor pops and
// compares them against beat/done outputs.
module tb_arb_requester4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd_valid;
  logic [15:0] cmd_len;
  logic [3:0]  cmd_ready;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        beat_valid;
  logic [1:0]  beat_port;
  logic        beat_last;
  logic [3:0]  done;
  logic        err;

  typedef struct {
    logic [1:0] port;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt[4] = '{0, 0, 0, 0};
  bit    mon_en = 1'b0;

  arb_requester4 #(.MAXLEN(16), .LENW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .req       (req),
    .grant     (grant),
    .beat_valid(beat_valid),
    .beat_port (beat_port),
    .beat_last (beat_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] ports, input logic [3:0] len);
    for (int i = 0; i < 4; i++) begin
      if (ports[i]) begin
        cmd_valid[i]      = 1'b1;
        cmd_len[i*4 +: 4] = len;
      end
    end
    step();
    cmd_valid = '0;
  endtask

  // Apply a grant for one cycle; exp_req is the request vector during it.
  task automatic gnt(input logic [3:0] g, input bit beat, input logic [1:0] p,
                     input bit last, input logic [3:0] exp_req);
    grant = g;
    #1;
    check("req_during_grant", req, exp_req);
    if (beat) exp_q.push_back('{p, last});
    step();
    grant = '0;
  endtask

  initial begin : monitor
    beat_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
      if (beat_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", beat_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_port", beat_port, e.port);
          check("beat_last", beat_last, e.last);
          check("done_pulse", done, e.last ? (4'b0001 << e.port) : 4'b0000);
        end
      end else begin
        check("idle_outputs", {beat_port, beat_last, done}, '0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    rst       = 1'b1;
    cmd_valid = '0;
    cmd_len   = '0;
    grant     = '0;
    step();
    mon_en = 1'b1;
    step();
    check("rst_req", req, 4'b0000);
    check("rst_cmd_ready", cmd_ready, 4'b1111);
    check("rst_beat", {beat_valid, beat_port, beat_last}, '0);
    check("rst_done", done, 4'b0000);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    // Single port, 3 beats
    accept(4'b0001, 4'd2);
    check("t1_cmd_ready", cmd_ready, 4'b1110);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0001);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0001);
    gnt(4'b0001, 1, 2'd0, 1, 4'b0000);
    step();

    // Contention between ports 0 and 2
    accept(4'b0101, 4'd1);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0101);
    gnt(4'b0100, 1, 2'd2, 0, 4'b0101);
    gnt(4'b0001, 1, 2'd0, 1, 4'b0100);
    gnt(4'b0100, 1, 2'd2, 1, 4'b0000);
    check("t2_err", err, 1'b0);

    // Back-to-back on port 1, new command offered during the done cycle
    accept(4'b0010, 4'd0);
    gnt(4'b0010, 1, 2'd1, 1, 4'b0000);
    cmd_valid[1]  = 1'b1;
    cmd_len[7:4]  = 4'd1;
    #1;
    check("t3_ready_in_done_cycle", cmd_ready[1], 1'b1);
    step();
    cmd_valid = '0;
    #1;
    check("t3_req_next_cycle", req, 4'b0010);
    gnt(4'b0010, 1, 2'd1, 0, 4'b0010);
    gnt(4'b0010, 1, 2'd1, 1, 4'b0000);

    // Maximum length on port 3
    accept(4'b1000, 4'd15);
    for (int k = 0; k < 16; k++) begin
      gnt(4'b1000, 1, 2'd3, (k == 15), (k == 15) ? 4'b0000 : 4'b1000);
    end
    check("t4_cmd_ready", cmd_ready, 4'b1111);
    check("t4_err", err, 1'b0);

    // Protocol errors: grant to an idle port, then a two-hot grant
    gnt(4'b0100, 0, 2'd0, 0, 4'b0000);
    check("t5_err_idle_grant", err, 1'b1);
    accept(4'b0011, 4'd0);
    gnt(4'b0011, 0, 2'd0, 0, 4'b0000);
    check("t5_err_sticky", err, 1'b1);
    check("t5_no_consume", cmd_ready, 4'b1100);
    gnt(4'b0001, 1, 2'd0, 1, 4'b0010);
    gnt(4'b0010, 1, 2'd1, 1, 4'b0000);
    check("t5_err_still", err, 1'b1);

    // Reset mid-command
    rst = 1'b1;
    step();
    check("t6_err_cleared", err, 1'b0);
    rst = 1'b0;
    accept(4'b0001, 4'd3);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0001);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0001);
    rst = 1'b1;
    step();
    check("t6_req", req, 4'b0000);
    check("t6_cmd_ready", cmd_ready, 4'b1111);
    rst = 1'b0;
    step();
    accept(4'b0001, 4'd1);
    gnt(4'b0001, 1, 2'd0, 0, 4'b0001);
    gnt(4'b0001, 1, 2'd0, 1, 4'b0000);
    check("t6_err", err, 1'b0);

    // Grant in the first cycle after reset release
    rst = 1'b1;
    step();
    rst   = 1'b0;
    grant = 4'b0001;
    step();
    grant = '0;
    check("t7_err_after_reset", err, 1'b1);
    step();
    step();

    check("queue_empty", exp_q.size(), 0);
    check("done_cnt_p0", done_cnt[0], 4);
    check("done_cnt_p1", done_cnt[1], 3);
    check("done_cnt_p2", done_cnt[2], 1);
    check("done_cnt_p3", done_cnt[3], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_requester4.md
ARB_REQUESTER4 -- requirements
Module: arb_requester4

Interface
REQ-001 Parameter: MAXLEN, default 16, maximum beats per command.
REQ-002 Parameter: LENW, default 4, width of cmd_len; cmd_len encodes beats minus one, so LENW SHALL equal clog2(MAXLEN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  4  per-port command offered.
REQ-006 cmd_len  input  4*LENW  per-port beat count minus one; port i occupies bits [i*LENW +: LENW].
REQ-007 cmd_ready  output  4  per-port command accepted this cycle when cmd_valid[i] is also high.
REQ-008 req  output  4  request vector to the 4-way round-robin arbiter.
REQ-009 grant  input  4  registered one-hot-or-zero grant from the arbiter.
REQ-010 beat_valid  output  1  registered; one beat consumed last cycle.
REQ-011 beat_port  output  2  registered; index of the port that consumed the beat.
REQ-012 beat_last  output  1  registered; consumed beat was the final beat of its command.
REQ-013 done  output  4  registered one-cycle pulse per port on command completion.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Each port SHALL hold one command: per-port pending bit plus remaining-beat counter of LENW+1 bits.
REQ-016 Per-port states: IDLE (pending=0) and ACTIVE (pending=1); no other states.
REQ-017 cmd_ready[i] SHALL equal ~pending[i]; acceptance (cmd_valid[i] & cmd_ready[i]) loads remaining = cmd_len+1 and enters ACTIVE on the next edge.
REQ-018 A command accepted at edge t SHALL first raise req[i] in the cycle following edge t, giving one cycle from acceptance to request.
REQ-019 Each cycle with grant[i]=1 and pending[i]=1 SHALL consume exactly one beat of port i: remaining decrements by 1.
REQ-020 When remaining reaches 0 after a consumed beat, the port SHALL return to IDLE at the same edge.
REQ-021 req[i] SHALL be combinational: pending[i] & ~(grant[i] & remaining[i]==1), dropping in the final-beat grant cycle so that the arbiter cannot issue a trailing grant.
REQ-022 The arbiter rotates grants every cycle when multiple ports request, so grants are treated as single-beat tokens; a port SHALL NOT assume consecutive grants.
REQ-023 The cycle after a consuming grant, the outputs SHALL be: beat_valid=1, beat_port equal to the index of the granted port, and beat_last=1 if it was the final beat; otherwise beat_valid=0 and beat_port and beat_last hold 0.
REQ-024 done[i] SHALL pulse for one cycle, coincident with beat_valid/beat_last of the final beat of port i.
REQ-025 A port in IDLE after completion MAY accept a new command in the same cycle its done pulses; the earliest re-request follows REQ-018.
REQ-026 err SHALL set, and remain set until reset, if grant has more than one bit set or grant[i]=1 while pending[i]=0.
REQ-027 An erroneous grant SHALL consume no beat, and beat_valid SHALL remain 0 for it.
REQ-028 cmd_len = MAXLEN-1 SHALL produce exactly MAXLEN beats, with no counter overflow.

Reset
REQ-029 While rst=1: pending=0, remaining=0, beat_valid=0, beat_port=0, beat_last=0, done=0, err=0; therefore req=0 and cmd_ready=4'b1111.
REQ-030 Reset mid-command SHALL discard all outstanding beats with no done pulse; a grant arriving in the cycle after reset release SHALL set err.

Structure
REQ-031 Port count (4), port-index width (2) and the cmd_len field slicing SHALL be defined as constants in the shared arbiter package, which the arbiter also uses.
REQ-032 One sub-module, arb_req_port, SHALL implement a single port's pending bit, counter and req logic; it SHALL be instantiated 4 times, and the top level holds the beat/done/err registers.

Verification
REQ-033 Single port: port0 len=2 (3 beats), arbiter grants 0001 for 3 cycles -> 3 beats on port 0, beat_last on the third, done[0] pulses once, req[0] low during the third grant.
REQ-034 Contention: ports 0 and 2 each len=1 -> beat_port sequence 0,2,0,2 under round-robin, both done pulses, err=0.
REQ-035 Back-to-back: port1 new command offered during the done cycle -> accepted, req[1] rises the next cycle, no idle gap beyond REQ-018.
REQ-036 Max length: port3 len=MAXLEN-1 -> exactly MAXLEN beats, single done[3].
REQ-037 Protocol error: grant=0100 while port2 IDLE, then grant=0011 -> err set and sticky, no beat_valid for either.
REQ-038 Reset at beat 2 of a 4-beat command -> req=0, cmd_ready=1111, no done pulse; a fresh command completes normally.
